// File: rtl/imm_ext_stage.sv
// Immediate extender with a 2-entry skid buffer between decode and execute.
// Define IMM_EXT_BR_TARGET_EN to make branch mode emit pc + 4 + offset instead of the offset.
module imm_ext_stage #(
    parameter int unsigned IMM_W    = 16,
    parameter int unsigned OUT_W    = 32,
    parameter int unsigned BR_SHAMT = 2,
    parameter int unsigned TAG_W    = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_mode,
    input  logic [25:0]      in_imm,
    input  logic [OUT_W-1:0] in_pc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    localparam int unsigned ENT_W = OUT_W + TAG_W + 1;
    localparam logic [OUT_W-1:0] JMP_MASK = {OUT_W{1'b1}} >> (OUT_W - 28);

    localparam logic [2:0] MODE_SIGN   = 3'd0;
    localparam logic [2:0] MODE_ZERO   = 3'd1;
    localparam logic [2:0] MODE_BRANCH = 3'd2;
    localparam logic [2:0] MODE_LUI    = 3'd3;
    localparam logic [2:0] MODE_JUMP   = 3'd4;

    logic [OUT_W-1:0] imm_sext, imm_zext, br_off, jmp_val, ext_data;
    logic             ext_err;
    logic [ENT_W-1:0] in_ent;
    logic             in_xfer;

    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [ENT_W-1:0] out_ent_q, out_ent_d;
    logic [ENT_W-1:0] skid_ent_q, skid_ent_d;

    always_comb begin
        imm_sext = {{(OUT_W - IMM_W){in_imm[IMM_W-1]}}, in_imm[IMM_W-1:0]};
        imm_zext = {{(OUT_W - IMM_W){1'b0}}, in_imm[IMM_W-1:0]};
        br_off   = imm_sext << BR_SHAMT;
        // PC region bits above the 28-bit jump window are kept from the instruction's PC.
        jmp_val  = (in_pc & ~JMP_MASK) | ({{(OUT_W - 26){1'b0}}, in_imm} << 2);
    end

    always_comb begin
        ext_data = '0;
        ext_err  = 1'b0;
        case (in_mode)
            MODE_SIGN:   ext_data = imm_sext;
            MODE_ZERO:   ext_data = imm_zext;
`ifdef IMM_EXT_BR_TARGET_EN
            MODE_BRANCH: ext_data = in_pc + {{(OUT_W - 3){1'b0}}, 3'd4} + br_off;
`else
            MODE_BRANCH: ext_data = br_off;
`endif
            MODE_LUI:    ext_data = imm_zext << IMM_W;
            MODE_JUMP:   ext_data = jmp_val;
            default:     ext_err  = 1'b1;
        endcase
    end

    assign in_ent   = {ext_err, in_tag, ext_data};
    assign in_ready = !skid_valid_q;
    assign in_xfer  = in_valid && !skid_valid_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        out_ent_d    = out_ent_q;
        skid_ent_d   = skid_ent_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_ready) begin
            // Output register frees up: skid drains first to keep FIFO order.
            if (skid_valid_q) begin
                out_ent_d    = skid_ent_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = in_xfer;
                if (in_xfer) begin
                    out_ent_d = in_ent;
                end
            end
        end else if (in_xfer) begin
            skid_ent_d   = in_ent;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_ent_q    <= '0;
            skid_ent_q   <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            out_ent_q    <= out_ent_d;
            skid_ent_q   <= skid_ent_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_ent_q[OUT_W-1:0];
    assign out_tag   = out_ent_q[OUT_W+TAG_W-1:OUT_W];
    assign out_err   = out_ent_q[ENT_W-1];

endmodule

// File: tb/tb_imm_ext_stage.sv
// Scoreboard bench for imm_ext_stage: expected entries queued on accept, compared on output transfer.
module tb_imm_ext_stage;

    logic        clk = 1'b0;
    logic        resetn, flush, in_valid, in_ready, out_valid, out_ready, out_err;
    logic [2:0]  in_mode;
    logic [25:0] in_imm;
    logic [31:0] in_pc, out_data;
    logic [7:0]  in_tag, out_tag;

    typedef struct packed {
        logic        err;
        logic [7:0]  tag;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   rand_rdy = 1'b0;

    imm_ext_stage dut (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_imm    (in_imm),
        .in_pc     (in_pc),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic exp_t model(input logic [2:0] m, input logic [25:0] imm,
                                   input logic [31:0] pc, input logic [7:0] tag);
        exp_t        e;
        logic [15:0] i;
        logic [31:0] off;
        i     = imm[15:0];
        off   = {{14{i[15]}}, i, 2'b00};
        e.tag = tag;
        e.err = 1'b0;
        case (m)
            3'd0: e.data = {{16{i[15]}}, i};
            3'd1: e.data = {16'h0000, i};
`ifdef IMM_EXT_BR_TARGET_EN
            3'd2: e.data = pc + 32'd4 + off;
`else
            3'd2: e.data = off;
`endif
            3'd3: e.data = {i, 16'h0000};
            3'd4: e.data = {pc[31:28], imm, 2'b00};
            default: begin
                e.data = 32'h0;
                e.err  = 1'b1;
            end
        endcase
        return e;
    endfunction

    // Scoreboard: inputs change at posedge+1, so the negedge sees settled handshakes.
    always @(negedge clk) begin
        if (!resetn || flush) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_out", exp_q.size(), 1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_eq("sb_tag", out_tag, e.tag);
                    check_eq("sb_data", out_data, e.data);
                    check_eq("sb_err", out_err, e.err);
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_mode, in_imm, in_pc, in_tag));
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [2:0] m, input logic [25:0] imm, input logic [31:0] pc,
                         input logic [7:0] tag);
        in_valid = 1'b1;
        in_mode  = m;
        in_imm   = imm;
        in_pc    = pc;
        in_tag   = tag;
    endtask

    // Waits for the offered item to be accepted; returns at posedge+1 after the accepting edge.
    task automatic wait_accept();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq("accept_timeout", 0, 1);
        sync();
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [2:0] m, input logic [25:0] imm, input logic [31:0] pc,
                        input logic [7:0] tag);
        offer(m, imm, pc, tag);
        wait_accept();
    endtask

    initial begin
        resetn    = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_mode   = 3'd0;
        in_imm    = '0;
        in_pc     = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_tag", out_tag, 0);
        sync();
        resetn = 1'b1;
        @(negedge clk);
        check_eq("rst_in_ready", in_ready, 1);
        sync();

        // Latency and basic modes.
        send(3'd0, 26'h8001, 32'h0, 8'h01);
        @(negedge clk);
        check_eq("lat_valid", out_valid, 1);
        check_eq("lat_data", out_data, 32'hFFFF8001);
        check_eq("lat_err", out_err, 0);
        sync();
        send(3'd1, 26'h8001, 32'h0, 8'h02);
        send(3'd3, 26'h1234, 32'h0, 8'h03);
        send(3'd4, 26'h3FFFFFF, 32'hA0001000, 8'h04);
        send(3'd2, 26'hFFFF, 32'h00400010, 8'h05);
        send(3'd6, 26'h1234, 32'h0, 8'h06);
        send(3'd7, 26'h0, 32'h0, 8'h07);
        send(3'd0, 26'h7FFF, 32'h0, 8'h08);
        sync();

        // Back-pressure: two items held, third blocked.
        out_ready = 1'b0;
        send(3'd1, 26'h0011, 32'h0, 8'h01);
        send(3'd1, 26'h0022, 32'h0, 8'h02);
        offer(3'd1, 26'h0033, 32'h0, 8'h03);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_eq("bp_in_ready", in_ready, 0);
            check_eq("bp_hold_tag", out_tag, 8'h01);
            check_eq("bp_hold_data", out_data, 32'h00000011);
        end
        sync();
        out_ready = 1'b1;
        wait_accept();
        sync();
        sync();

        // Flush with both entries held and a third offered.
        out_ready = 1'b0;
        send(3'd0, 26'h0010, 32'h0, 8'h10);
        send(3'd0, 26'h0011, 32'h0, 8'h11);
        offer(3'd0, 26'h0012, 32'h0, 8'h12);
        flush = 1'b1;
        sync();
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("flush_out_valid", out_valid, 0);
        check_eq("flush_in_ready", in_ready, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("flush_idle", out_valid, 0);
        end
        sync();
        send(3'd1, 26'h0013, 32'h0, 8'h13);
        sync();

        // Reset mid-stream.
        out_ready = 1'b0;
        send(3'd0, 26'h0020, 32'h0, 8'h20);
        send(3'd0, 26'h0021, 32'h0, 8'h21);
        resetn = 1'b0;
        sync();
        resetn = 1'b1;
        @(negedge clk);
        check_eq("mrst_out_valid", out_valid, 0);
        check_eq("mrst_in_ready", in_ready, 1);
        check_eq("mrst_out_tag", out_tag, 0);
        check_eq("mrst_out_data", out_data, 0);
        sync();
        out_ready = 1'b1;

        // Random traffic under random back-pressure.
        rand_rdy = 1'b1;
        for (int n = 0; n < 40; n++) begin
            send(3'($urandom_range(0, 7)), 26'($urandom), $urandom, 8'(8'h40 + n));
        end
        rand_rdy = 1'b0;
        sync();
        out_ready = 1'b1;

        for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(posedge clk);
        @(negedge clk);
        check_eq("drain_empty", exp_q.size(), 0);
        check_eq("drain_out_valid", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
